// File: rtl/wimax_pkg.sv
// Shared WiMAX PHY TX definitions: burst controller state encoding and block geometry.
package wimax_pkg;

  localparam int unsigned WIMAX_BLOCK_BITS = 96;
  localparam int unsigned WIMAX_SEED_W     = 15;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN,
    DONE
  } phy_ctrl_state_t;

endpackage

// File: rtl/phy_ctrl_watchdog.sv
// STREAM stall watchdog: counts cycles without a transfer and raises a sticky error.
// Built into phy_burst_ctrl only when PHY_CTRL_TIMEOUT_EN is defined.
module phy_ctrl_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 11
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic active_i,
  input  logic xfer_i,
  output logic expire_o,
  output logic err_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_comb begin
    expire_o = active_i & ~xfer_i & (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (!active_i || xfer_i || expire_o) cnt_d = '0;
    else                                 cnt_d = cnt_q + CNT_W'(1);
    if (clr_i)         err_d = 1'b0;
    else if (expire_o) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

endmodule

// File: rtl/phy_burst_ctrl.sv
// Burst sequencer at the head of the WiMAX PHY TX chain: reseeds the PRBS per 96-bit block,
// gates the upstream bit source, drains the pipeline and pulses done. Option: PHY_CTRL_TIMEOUT_EN.
module phy_burst_ctrl
  import wimax_pkg::*;
#(
  parameter int unsigned BLOCK_BITS     = WIMAX_BLOCK_BITS,
  parameter int unsigned SEED_W         = WIMAX_SEED_W,
  parameter int unsigned BLK_CNT_W      = 8,
  parameter int unsigned DRAIN_CYCLES   = 400,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk_50,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BLK_CNT_W-1:0] num_blocks,
  input  logic [SEED_W-1:0]    seed,
  input  logic                 src_valid,
  input  logic                 src_data,
  output logic                 src_ready,
  output logic                 prbs_load,
  output logic                 prbs_en,
  output logic [SEED_W-1:0]    prbs_seed,
  output logic                 prbs_valid,
  output logic                 prbs_data,
  input  logic                 prbs_ready,
  output logic                 busy,
  output logic                 done,
  output logic [BLK_CNT_W-1:0] blk_cnt,
  output logic                 err_timeout
);

  localparam int unsigned BIT_W   = $clog2(BLOCK_BITS);
  // One width covers both the drain counter and the stall counter.
  localparam int unsigned CNT_MAX = (DRAIN_CYCLES > TIMEOUT_CYCLES) ? DRAIN_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  phy_ctrl_state_t       state_q;
  logic [BLK_CNT_W-1:0]  num_blocks_q, blk_cnt_q, blk_cnt_d;
  logic [SEED_W-1:0]     seed_q;
  logic [BIT_W-1:0]      bit_cnt_q;
  logic [CNT_W-1:0]      drain_cnt_q;
  logic                  prbs_load_q, prbs_en_q, busy_q, done_q;
  logic                  streaming, xfer, blk_end, accept, expire;

  assign streaming  = (state_q == STREAM);
  assign src_ready  = streaming & prbs_ready;
  assign prbs_valid = streaming & src_valid;
  assign prbs_data  = streaming & src_data;
  assign xfer       = streaming & src_valid & prbs_ready;
  assign blk_end    = xfer & (bit_cnt_q == BIT_W'(BLOCK_BITS - 1));
  assign blk_cnt_d  = blk_cnt_q + BLK_CNT_W'(1);
  assign accept     = (state_q == IDLE) & start;

`ifdef PHY_CTRL_TIMEOUT_EN
  phy_ctrl_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clk_i    (clk_50),
    .rst_i    (reset),
    .clr_i    (accept),
    .active_i (streaming),
    .xfer_i   (xfer),
    .expire_o (expire),
    .err_o    (err_timeout)
  );
`else
  assign expire      = 1'b0;
  assign err_timeout = 1'b0;
`endif

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      num_blocks_q <= '0;
      blk_cnt_q    <= '0;
      seed_q       <= '0;
      bit_cnt_q    <= '0;
      drain_cnt_q  <= '0;
      prbs_load_q  <= 1'b0;
      prbs_en_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      prbs_load_q <= 1'b0;
      done_q      <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            seed_q       <= seed;
            num_blocks_q <= num_blocks;
            blk_cnt_q    <= '0;
            busy_q       <= 1'b1;
            if (num_blocks == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q     <= LOAD;
              prbs_load_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          bit_cnt_q <= '0;
          prbs_en_q <= 1'b1;
          state_q   <= STREAM;
        end
        STREAM: begin
          if (expire) begin
            state_q   <= IDLE;
            prbs_en_q <= 1'b0;
            busy_q    <= 1'b0;
          end else if (blk_end) begin
            bit_cnt_q <= '0;
            blk_cnt_q <= blk_cnt_d;
            prbs_en_q <= 1'b0;
            if (blk_cnt_d == num_blocks_q) begin
              state_q     <= DRAIN;
              drain_cnt_q <= '0;
            end else begin
              state_q     <= LOAD;
              prbs_load_q <= 1'b1;
            end
          end else if (xfer) begin
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
        end
        DRAIN: begin
          // Counter parks at its terminal value on the exit cycle rather than wrapping.
          if (drain_cnt_q == CNT_W'(DRAIN_CYCLES)) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            drain_cnt_q <= drain_cnt_q + CNT_W'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= IDLE;
          prbs_en_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign prbs_load = prbs_load_q;
  assign prbs_en   = prbs_en_q;
  assign prbs_seed = seed_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign blk_cnt   = blk_cnt_q;

endmodule

// File: tb/tb_phy_burst_ctrl.sv
// Directed bench for phy_burst_ctrl with a bit scoreboard on the source/randomizer handshake.
// Covers both builds of PHY_CTRL_TIMEOUT_EN.
module tb_phy_burst_ctrl;
  import wimax_pkg::*;

  localparam int DRAIN = 20;
  localparam int TMO   = 16;
  localparam int BLK   = WIMAX_BLOCK_BITS + 1;

  logic        clk_50 = 1'b0;
  logic        reset, start, src_valid, src_data, prbs_ready;
  logic [7:0]  num_blocks;
  logic [14:0] seed;
  logic        src_ready, prbs_load, prbs_en, prbs_valid, prbs_data, busy, done, err_timeout;
  logic [14:0] prbs_seed;
  logic [7:0]  blk_cnt;

  int checks = 0, failures = 0, cyc = 0;
  int xfers = 0, done_cnt = 0, done_cyc = -1, err_cyc = -1, last_xfer_cyc = -1;
  int mirror_err = 0, done_busy = 0;
  int load_q[$];
  logic sb[$];
  bit toggle_ready = 1'b0;

  phy_burst_ctrl #(
    .DRAIN_CYCLES   (DRAIN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_50      (clk_50),
    .reset       (reset),
    .start       (start),
    .num_blocks  (num_blocks),
    .seed        (seed),
    .src_valid   (src_valid),
    .src_data    (src_data),
    .src_ready   (src_ready),
    .prbs_load   (prbs_load),
    .prbs_en     (prbs_en),
    .prbs_seed   (prbs_seed),
    .prbs_valid  (prbs_valid),
    .prbs_data   (prbs_data),
    .prbs_ready  (prbs_ready),
    .busy        (busy),
    .done        (done),
    .blk_cnt     (blk_cnt),
    .err_timeout (err_timeout)
  );

  always #10 clk_50 = ~clk_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  function automatic logic [31:0] outs();
    return {1'b0, prbs_seed, blk_cnt, src_ready, prbs_load, prbs_en, prbs_valid,
            prbs_data, busy, done, err_timeout};
  endfunction

  // Sample at negedge, advance one clock, then drive the next source bit.
  task automatic step();
    logic exp_bit;
    bit   accepted = 1'b0;
    @(negedge clk_50);
    if (prbs_load) load_q.push_back(cyc);
    if (done) begin done_cnt++; done_cyc = cyc; done_busy = int'(busy); end
    if (err_timeout && err_cyc < 0) err_cyc = cyc;
    if (src_ready !== (prbs_en ? prbs_ready : 1'b0)) mirror_err++;
    if (prbs_valid !== (prbs_en ? src_valid : 1'b0)) mirror_err++;
    if (src_valid && src_ready) begin
      xfers++;
      last_xfer_cyc = cyc;
      accepted = 1'b1;
      if (sb.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_bit = sb.pop_front();
        chk("prbs_data", {31'd0, prbs_data}, {31'd0, exp_bit});
      end
    end
    @(posedge clk_50);
    #1;
    cyc++;
    if (accepted && src_valid) begin
      src_data = 1'($urandom_range(0, 1));
      sb.push_back(src_data);
    end
    if (toggle_ready) prbs_ready = ~prbs_ready;
  endtask

  task automatic start_burst(input logic [7:0] nb, input logic [14:0] sd);
    sb.delete();
    load_q.delete();
    xfers = 0; done_cnt = 0; done_cyc = -1; err_cyc = -1; last_xfer_cyc = -1;
    num_blocks = nb;
    seed       = sd;
    src_data   = 1'($urandom_range(0, 1));
    sb.push_back(src_data);
    start = 1'b1;
    cyc   = 0;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      step();
      n++;
    end
    chk("done_within_budget", (done_cnt != 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; num_blocks = '0; seed = '0;
    src_valid = 1'b0; src_data = 1'b0; prbs_ready = 1'b1;
    repeat (3) step();
    chk("reset_outputs", outs(), 32'd0);
    reset = 1'b0;
    repeat (2) step();
    chk("idle_outputs", outs(), 32'd0);

    // Asynchronous reset in STREAM at bit 40, then a clean single-block burst.
    src_valid = 1'b1;
    start_burst(8'd1, 15'h2B1D);
    n = 0;
    while (xfers < 40 && n < 200) begin step(); n++; end
    chk("reached_bit40", xfers, 40);
    #2 reset = 1'b1;
    #1 chk("async_reset_outputs", outs(), 32'd0);
    repeat (3) step();
    chk("no_done_on_reset", done_cnt, 0);
    reset = 1'b0;
    step();
    start_burst(8'd1, 15'h0011);
    wait_done(400);
    chk("clean_done_cycle", done_cyc, BLK + DRAIN + 2);
    chk("clean_xfers", xfers, 96);
    chk("clean_blk_cnt", {24'd0, blk_cnt}, 32'd1);

    // Two blocks, continuous flow.
    start_burst(8'd2, 15'h4A80);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    wait_done(600);
    chk("load_count", load_q.size(), 2);
    chk("load0_cycle", (load_q.size() > 0) ? load_q[0] : -1, 1);
    chk("load1_cycle", (load_q.size() > 1) ? load_q[1] : -1, 1 + BLK);
    chk("two_blk_xfers", xfers, 192);
    chk("two_blk_done_cycle", done_cyc, 2 * BLK + DRAIN + 2);
    chk("busy_on_done", done_busy, 1);
    chk("two_blk_cnt", {24'd0, blk_cnt}, 32'd2);
    chk("two_blk_seed", {17'd0, prbs_seed}, 32'h4A80);
    chk("busy_after_done", {31'd0, busy}, 32'd0);

    // Backpressure toggling every cycle.
    mirror_err   = 0;
    toggle_ready = 1'b1;
    start_burst(8'd1, 15'h1357);
    wait_done(800);
    toggle_ready = 1'b0;
    prbs_ready   = 1'b1;
    chk("toggle_xfers", xfers, 96);
    chk("toggle_mirror", mirror_err, 0);
    chk("toggle_sb_pending", sb.size(), 1);
    chk("toggle_blk_cnt", {24'd0, blk_cnt}, 32'd1);

    // Zero-block burst; a start on the DONE cycle must be ignored.
    start_burst(8'd0, 15'h0C0C);
    seed  = 15'h7777;
    num_blocks = 8'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    chk("zero_done_cycle", done_cyc, 1);
    chk("zero_done_count", done_cnt, 1);
    chk("zero_no_load", load_q.size(), 0);
    chk("zero_blk_cnt", {24'd0, blk_cnt}, 32'd0);
    chk("done_cycle_start_ignored", {31'd0, busy}, 32'd0);
    chk("zero_seed", {17'd0, prbs_seed}, 32'h0C0C);

    // Start while busy (STREAM and DRAIN) is ignored.
    start_burst(8'd1, 15'h1234);
    n = 0;
    while (done_cnt == 0 && n < 600) begin
      start      = (cyc == 50 || cyc == BLK + 1 + DRAIN / 2);
      seed       = 15'h7FFF;
      num_blocks = 8'd3;
      step();
      n++;
    end
    start = 1'b0;
    chk("busy_start_done", done_cnt, 1);
    chk("busy_start_done_cycle", done_cyc, BLK + DRAIN + 2);
    chk("busy_start_seed", {17'd0, prbs_seed}, 32'h1234);
    chk("busy_start_loads", load_q.size(), 1);
    chk("busy_start_blk_cnt", {24'd0, blk_cnt}, 32'd1);

    // Source stalls after 10 bits.
    start_burst(8'd1, 15'h0ABC);
    n = 0;
    while (xfers < 10 && n < 100) begin step(); n++; end
    src_valid = 1'b0;
    repeat (40) step();
`ifdef PHY_CTRL_TIMEOUT_EN
    chk("timeout_err_cycle", err_cyc, last_xfer_cyc + TMO + 1);
    chk("timeout_en_dropped", {31'd0, prbs_en}, 32'd0);
    chk("timeout_idle", {31'd0, busy}, 32'd0);
    chk("timeout_no_done", done_cnt, 0);
    chk("timeout_sticky", {31'd0, err_timeout}, 32'd1);
    src_valid = 1'b1;
    start_burst(8'd0, 15'h0001);
    chk("timeout_cleared_by_start", {31'd0, err_timeout}, 32'd0);
    repeat (3) step();
`else
    chk("stall_no_err", err_cyc, -1);
    chk("stall_still_stream", {31'd0, prbs_en}, 32'd1);
    chk("stall_busy", {31'd0, busy}, 32'd1);
    chk("stall_no_done", done_cnt, 0);
    src_valid = 1'b1;
    wait_done(400);
    chk("stall_xfers", xfers, 96);
    chk("stall_blk_cnt", {24'd0, blk_cnt}, 32'd1);
`endif
    chk("mirror_total", mirror_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
